// File: rtl/tslide_pkg.sv
// tslide_pkg: shared constants and counter-width helper for the tslide debounce block
package tslide_pkg;
  localparam int LED_W = 8;
  localparam int DB_CYCLES_25MHZ_10MS = 250000;
  function automatic int cnt_w(input int cycles);
    return $clog2(cycles);
  endfunction
endpackage

// File: rtl/tslide_debounce_if.sv
// tslide_debounce_if: switch/button inputs and debounced/LED outputs of tslide_debounce
// Ports: sw, pb_n (raw inputs); sw_state, pb_state, pb_press, pb_latch, pmodledg, pmodledr (results).
// TSLIDE_PRESSCNT_EN adds press_cnt.
interface tslide_debounce_if
  import tslide_pkg::*;
#(
  parameter int N_SW = 4,
  parameter int N_PB = 4
);
  logic [N_SW-1:0] sw;
  logic [N_PB-1:0] pb_n;
  logic [N_SW-1:0] sw_state;
  logic [N_PB-1:0] pb_state;
  logic [N_PB-1:0] pb_press;
  logic [N_PB-1:0] pb_latch;
  logic [LED_W-1:0] pmodledg;
  logic [LED_W-1:0] pmodledr;
`ifdef TSLIDE_PRESSCNT_EN
  logic [7:0] press_cnt;
  modport master (output sw, pb_n, input sw_state, pb_state, pb_press, pb_latch, pmodledg, pmodledr, press_cnt);
  modport slave (input sw, pb_n, output sw_state, pb_state, pb_press, pb_latch, pmodledg, pmodledr, press_cnt);
`else
  modport master (output sw, pb_n, input sw_state, pb_state, pb_press, pb_latch, pmodledg, pmodledr);
  modport slave (input sw, pb_n, output sw_state, pb_state, pb_press, pb_latch, pmodledg, pmodledr);
`endif
endinterface

// File: rtl/debounce_ch.sv
// debounce_ch: one channel of 2-flop synchroniser, debounce counter and stable register
// Ports: clk_25mhz, reset (sync, active-high), din (raw, active-high), dout (debounced).
module debounce_ch
  import tslide_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_25MHZ_10MS
) (
  input  logic clk_25mhz,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int CW = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stable_q, stable_d;
  logic synced;
  assign synced = sync_q[1];
  always_comb begin
    sync_d = {sync_q[0], din};
    cnt_d = (synced == stable_q || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    stable_d = (synced != stable_q && cnt_q == LAST) ? synced : stable_q;
  end
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      stable_q <= stable_d;
    end
  end
  assign dout = stable_q;
endmodule

// File: rtl/tslide_debounce.sv
// tslide_debounce: debounced slide switches and push buttons with press pulses, toggles and pmod LEDs
// Ports: clk_25mhz, reset (sync, active-high), io (tslide_debounce_if.slave).
// TSLIDE_PRESSCNT_EN adds an 8-bit press counter that also drives the red LEDs.
module tslide_debounce
  import tslide_pkg::*;
#(
  parameter int N_SW = 4,
  parameter int N_PB = 4,
  parameter int DB_CYCLES = DB_CYCLES_25MHZ_10MS,
  parameter int PB_TOGGLE = 0
) (
  input logic clk_25mhz,
  input logic reset,
  tslide_debounce_if.slave io
);
  logic [N_SW-1:0] sw_st;
  logic [N_PB-1:0] pb_st;
  logic [N_PB-1:0] pb_prev_q, pb_prev_d;
  logic [N_PB-1:0] pb_press_q, pb_press_d;
  logic [N_PB-1:0] pb_latch_q, pb_latch_d;
  logic [LED_W-1:0] led_g, led_r;
  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
      .clk_25mhz(clk_25mhz),
      .reset(reset),
      .din(io.sw[i]),
      .dout(sw_st[i])
    );
  end
  // buttons are inverted ahead of the synchroniser so every channel is active-high
  for (genvar i = 0; i < N_PB; i++) begin : g_pb
    debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
      .clk_25mhz(clk_25mhz),
      .reset(reset),
      .din(~io.pb_n[i]),
      .dout(pb_st[i])
    );
  end
  always_comb begin
    pb_prev_d = pb_st;
    pb_press_d = pb_st & ~pb_prev_q;
    pb_latch_d = pb_latch_q ^ pb_press_d;
  end
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      pb_prev_q <= '0;
      pb_press_q <= '0;
      pb_latch_q <= '0;
    end else begin
      pb_prev_q <= pb_prev_d;
      pb_press_q <= pb_press_d;
      pb_latch_q <= pb_latch_d;
    end
  end
`ifdef TSLIDE_PRESSCNT_EN
  logic [7:0] press_cnt_q, press_cnt_d;
  always_comb press_cnt_d = press_cnt_q + 8'($countones(pb_press_q));
  always_ff @(posedge clk_25mhz) begin
    if (reset) press_cnt_q <= '0;
    else press_cnt_q <= press_cnt_d;
  end
  assign io.press_cnt = press_cnt_q;
`endif
  // red bank is mirrored: button 0 lights bit 7
  always_comb begin
    led_g = '0;
    led_r = '0;
    for (int i = 0; i < N_SW; i++) led_g[i] = sw_st[i];
    for (int i = 0; i < N_PB; i++) led_r[LED_W-1-i] = (PB_TOGGLE != 0) ? pb_latch_q[i] : pb_st[i];
`ifdef TSLIDE_PRESSCNT_EN
    led_r = press_cnt_q;
`endif
  end
  assign io.sw_state = sw_st;
  assign io.pb_state = pb_st;
  assign io.pb_press = pb_press_q;
  assign io.pb_latch = pb_latch_q;
  assign io.pmodledg = led_g;
  assign io.pmodledr = led_r;
endmodule

// File: tb/tb_tslide_debounce.sv
// tb_tslide_debounce: directed checks of tslide_debounce with DB_CYCLES=4, momentary and toggle builds
module tb_tslide_debounce;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  int n;
  tslide_debounce_if #(.N_SW(4), .N_PB(4)) if0 ();
  tslide_debounce_if #(.N_SW(4), .N_PB(4)) if1 ();
  assign if1.sw = if0.sw;
  assign if1.pb_n = if0.pb_n;
  tslide_debounce #(.N_SW(4), .N_PB(4), .DB_CYCLES(4), .PB_TOGGLE(0)) dut0 (
    .clk_25mhz(clk), .reset(rst), .io(if0.slave));
  tslide_debounce #(.N_SW(4), .N_PB(4), .DB_CYCLES(4), .PB_TOGGLE(1)) dut1 (
    .clk_25mhz(clk), .reset(rst), .io(if1.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    if0.sw = 4'hF;
    if0.pb_n = 4'h0;
    tick(3);
    chk("rst_sw_state", 32'(if0.sw_state), 32'h0);
    chk("rst_pb_state", 32'(if0.pb_state), 32'h0);
    chk("rst_pb_press", 32'(if0.pb_press), 32'h0);
    chk("rst_pb_latch", 32'(if0.pb_latch), 32'h0);
    chk("rst_ledg", 32'(if0.pmodledg), 32'h0);
    chk("rst_ledr", 32'(if0.pmodledr), 32'h0);
    rst = 1'b0;
    tick(5);
    chk("rel5_sw_state", 32'(if0.sw_state), 32'h0);
    chk("rel5_pb_state", 32'(if0.pb_state), 32'h0);
    tick(1);
    chk("rel6_sw_state", 32'(if0.sw_state), 32'hF);
    chk("rel6_pb_state", 32'(if0.pb_state), 32'hF);
    chk("rel6_ledg", 32'(if0.pmodledg), 32'h0F);
`ifndef TSLIDE_PRESSCNT_EN
    chk("rel6_ledr", 32'(if0.pmodledr), 32'hF0);
`endif
    chk("rel6_press_early", 32'(if0.pb_press), 32'h0);
    tick(1);
    chk("rel7_press", 32'(if0.pb_press), 32'hF);
    chk("rel7_latch", 32'(if0.pb_latch), 32'hF);
`ifndef TSLIDE_PRESSCNT_EN
    chk("rel7_tog_ledr", 32'(if1.pmodledr), 32'hF0);
`endif
    tick(1);
    chk("rel8_press_off", 32'(if0.pb_press), 32'h0);
    if0.sw = 4'h0;
    if0.pb_n = 4'hF;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n += $countones(if0.pb_press);
    end
    chk("release_no_pulse", 32'(n), 32'h0);
    chk("release_state", 32'({if0.sw_state, if0.pb_state}), 32'h0);
    chk("release_latch", 32'(if0.pb_latch), 32'hF);
    if0.sw = 4'h1;
    tick(3);
    if0.sw = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("glitch_ledg", 32'(if0.pmodledg), 32'h0);
    end
    chk("glitch_sw_state", 32'(if0.sw_state), 32'h0);
    if0.sw = 4'h1;
    tick(5);
    chk("hold5_ledg", 32'(if0.pmodledg), 32'h0);
    tick(1);
    chk("hold6_ledg", 32'(if0.pmodledg), 32'h1);
    if0.pb_n = 4'b1101;
    tick(2);
    if0.pb_n = 4'b1111;
    tick(1);
    if0.pb_n = 4'b1101;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      n += int'(if0.pb_press[1]);
    end
    chk("bounce_pulses", 32'(n), 32'h1);
    chk("bounce_latch", 32'(if0.pb_latch), 32'hD);
`ifndef TSLIDE_PRESSCNT_EN
    chk("bounce_ledr", 32'(if0.pmodledr), 32'h40);
`endif
    if0.pb_n = 4'hF;
    if0.sw = 4'h0;
    tick(8);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("rst2_latch", 32'(if1.pb_latch), 32'h0);
    n = 0;
    for (int k = 0; k < 2; k++) begin
      if0.pb_n = 4'b1011;
      for (int i = 0; i < 10; i++) begin
        tick(1);
        n += int'(if1.pb_press[2]);
        chk("tog_press_width", 32'(if1.pb_press & (if1.pb_press >> 1) & 4'h3), 32'h0);
      end
`ifndef TSLIDE_PRESSCNT_EN
      chk("tog_ledr_pressed", 32'(if1.pmodledr), (k == 0) ? 32'h20 : 32'h00);
      chk("mom_ledr_pressed", 32'(if0.pmodledr), 32'h20);
`endif
      if0.pb_n = 4'hF;
      tick(8);
`ifndef TSLIDE_PRESSCNT_EN
      chk("tog_ledr_released", 32'(if1.pmodledr), (k == 0) ? 32'h20 : 32'h00);
      chk("mom_ledr_released", 32'(if0.pmodledr), 32'h00);
`endif
    end
    chk("tog_pulses", 32'(n), 32'h2);
    if0.pb_n = 4'b0111;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("midrst_state", 32'(if0.pb_state), 32'h0);
    rst = 1'b0;
    tick(5);
    chk("midrst_rel5", 32'(if0.pb_state), 32'h0);
    tick(1);
    chk("midrst_rel6", 32'(if0.pb_state), 32'h8);
    tick(1);
    chk("midrst_press", 32'(if0.pb_press), 32'h8);
    chk("midrst_latch", 32'(if0.pb_latch), 32'h8);
    if0.pb_n = 4'hF;
    tick(8);
`ifdef TSLIDE_PRESSCNT_EN
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("cnt_rst", 32'(if0.press_cnt), 32'h0);
    for (int k = 1; k <= 64; k++) begin
      if0.pb_n = 4'h0;
      tick(8);
      chk("cnt_value", 32'(if0.press_cnt), 32'((4 * k) % 256));
      chk("cnt_ledr", 32'(if0.pmodledr), 32'((4 * k) % 256));
      if0.pb_n = 4'hF;
      tick(8);
    end
    chk("cnt_latch", 32'(if0.pb_latch), 32'h0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
